// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the uart_tx requester arbiter and its
// round-robin picker.
package uart_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_REQ      = 4;
  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_MAX_BURST    = 16;
  localparam int DEF_IDLE_TIMEOUT = 8;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: grants the first set request strictly
// after ptr, scanning upward with wrap.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int ID_WIDTH = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]  winner,
  output logic [ID_WIDTH-1:0] winner_id,
  output logic                any
);

  // The found flag masks every candidate after the first hit.
  always_comb begin
    logic                found_s;
    logic [ID_WIDTH-1:0] cand_s;
    found_s   = 1'b0;
    cand_s    = '0;
    winner    = '0;
    winner_id = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_s         = ID_WIDTH'((int'(ptr) + i) % NUM_REQ);
      winner[cand_s] = req[cand_s] & ~found_s;
      winner_id      = (req[cand_s] && !found_s) ? cand_s : winner_id;
      found_s        = found_s | req[cand_s];
    end
  end

  assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin burst arbiter sharing one uart_tx parallel input among
// NUM_REQ byte streams, with a single registered output stage.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int MAX_BURST    = DEF_MAX_BURST,
  parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT,
  parameter int ID_WIDTH     = clog2(NUM_REQ)
) (
  input  logic                          pclk_i,
  input  logic                          prst_n_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [DATA_WIDTH-1:0]         tx_pdata_o,
  output logic                          tx_pdata_valid_o,
  input  logic                          tx_pready_i,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic [ID_WIDTH-1:0]           grant_id_o,
  output logic                          busy_o
);

  localparam logic [7:0]          BURST_END = 8'(MAX_BURST - 1);
  localparam logic [7:0]          IDLE_END  = 8'(IDLE_TIMEOUT - 1);
  localparam logic [ID_WIDTH-1:0] PTR_RESET = ID_WIDTH'(NUM_REQ - 1);

  arb_state_e            state_r, state_s;
  logic [NUM_REQ-1:0]    grant_r, grant_s;
  logic [ID_WIDTH-1:0]   grant_id_r, grant_id_s;
  logic [ID_WIDTH-1:0]   last_ptr_r, last_ptr_s;
  logic [7:0]            burst_cnt_r, burst_cnt_s;
  logic [7:0]            idle_cnt_r, idle_cnt_s;
  logic [DATA_WIDTH-1:0] pdata_r;
  logic                  pvalid_r;

  logic [NUM_REQ-1:0]    pick_s;
  logic [ID_WIDTH-1:0]   pick_id_s;
  logic                  pick_any_s;
  logic                  xfer_s, room_s, valid_g_s, last_g_s, load_s, release_s;
  logic [DATA_WIDTH-1:0] data_g_s;

  rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .req       (req_valid_i),
    .ptr       (last_ptr_r),
    .winner    (pick_s),
    .winner_id (pick_id_s),
    .any       (pick_any_s)
  );

  assign xfer_s    = (state_r == ST_XFER);
  assign room_s    = !pvalid_r || tx_pready_i;
  assign valid_g_s = req_valid_i[grant_id_r];
  assign last_g_s  = req_last_i[grant_id_r];
  assign data_g_s  = req_data_i[int'(grant_id_r)*DATA_WIDTH +: DATA_WIDTH];
  assign load_s    = xfer_s && valid_g_s && room_s;

  // Any combination of last, cap and timeout collapses into one release.
  assign release_s = xfer_s &&
                     ((load_s && (last_g_s || (burst_cnt_r == BURST_END))) ||
                      (!valid_g_s && (idle_cnt_r == IDLE_END)));

  // Next-state, grant and burst/idle counter update.
  always_comb begin
    state_s     = state_r;
    grant_s     = grant_r;
    grant_id_s  = grant_id_r;
    last_ptr_s  = last_ptr_r;
    burst_cnt_s = burst_cnt_r;
    idle_cnt_s  = idle_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_any_s) begin
          state_s     = ST_XFER;
          grant_s     = pick_s;
          grant_id_s  = pick_id_s;
          last_ptr_s  = pick_id_s;
          burst_cnt_s = 8'd0;
          idle_cnt_s  = 8'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (load_s) begin
          burst_cnt_s = burst_cnt_r + 8'd1;
          idle_cnt_s  = 8'd0;
        end else if (!valid_g_s) begin
          idle_cnt_s = idle_cnt_r + 8'd1;
        end else begin
          idle_cnt_s = idle_cnt_r;
        end
        if (release_s) begin
          state_s = ST_IDLE;
          grant_s = '0;
        end else begin
          state_s = ST_XFER;
        end
      end
      default: begin
        state_s = ST_IDLE;
        grant_s = '0;
      end
    endcase
  end

  // Arbitration state register.
  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) begin
      state_r     <= ST_IDLE;
      grant_r     <= '0;
      grant_id_r  <= '0;
      last_ptr_r  <= PTR_RESET;
      burst_cnt_r <= 8'd0;
      idle_cnt_r  <= 8'd0;
    end else begin
      state_r     <= state_s;
      grant_r     <= grant_s;
      grant_id_r  <= grant_id_s;
      last_ptr_r  <= last_ptr_s;
      burst_cnt_r <= burst_cnt_s;
      idle_cnt_r  <= idle_cnt_s;
    end
  end

  // Output byte register; a held byte drains even after the grant is gone.
  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) begin
      pdata_r  <= '0;
      pvalid_r <= 1'b0;
    end else if (load_s) begin
      pdata_r  <= data_g_s;
      pvalid_r <= 1'b1;
    end else if (tx_pready_i) begin
      pvalid_r <= 1'b0;
    end else begin
      pvalid_r <= pvalid_r;
    end
  end

  assign req_ready_o      = (xfer_s && room_s) ? grant_r : '0;
  assign tx_pdata_o       = pdata_r;
  assign tx_pdata_valid_o = pvalid_r;
  assign grant_o          = grant_r;
  assign grant_id_o       = grant_id_r;
  assign busy_o           = xfer_s || pvalid_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus a
// randomized run checked against a transaction-level round-robin model.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int IT = 8;

  logic          clk = 1'b0;
  logic          prst_n;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0] req_valid, req_last, req_ready;
  logic [DW-1:0] tx_pdata;
  logic          tx_pdata_valid, tx_pready;
  logic [NR-1:0] grant;
  logic [1:0]    grant_id;
  logic          busy;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int pready_mode = 1;

  logic [7:0] src_data [NR][128];
  logic       src_last [NR][128];
  int         src_head [NR];
  int         src_len  [NR];
  logic       src_en   [NR];
  int         acc_edge [NR];
  logic [7:0] obs_q[$];
  int         glog[$];
  logic [NR-1:0] prev_grant;

  uart_tx_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB), .IDLE_TIMEOUT(IT), .ID_WIDTH(2)
  ) dut (
    .pclk_i(clk), .prst_n_i(prst_n), .req_data_i(req_data), .req_valid_i(req_valid),
    .req_last_i(req_last), .req_ready_o(req_ready), .tx_pdata_o(tx_pdata),
    .tx_pdata_valid_o(tx_pdata_valid), .tx_pready_i(tx_pready), .grant_o(grant),
    .grant_id_o(grant_id), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic push_src(input int k, input logic [7:0] d, input logic l);
    src_data[k][src_len[k]] = d;
    src_last[k][src_len[k]] = l;
    src_len[k] = src_len[k] + 1;
  endtask

  task automatic do_reset();
    prst_n = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0; tx_pready = 1'b1;
    pready_mode = 1;
    for (int k = 0; k < NR; k++) begin
      src_head[k] = 0; src_len[k] = 0; src_en[k] = 1'b1; acc_edge[k] = 0;
    end
    obs_q.delete(); glog.delete(); prev_grant = '0;
    repeat (2) @(posedge clk);
    #3 prst_n = 1'b1;
  endtask

  // One clock: drive sources after the edge, then sample what the next edge will transfer.
  task automatic step();
    @(posedge clk);
    cyc = cyc + 1;
    #1;
    for (int k = 0; k < NR; k++) begin
      if (src_en[k] && (src_head[k] < src_len[k])) begin
        req_valid[k] = 1'b1;
        req_data[k*DW +: DW] = src_data[k][src_head[k]];
        req_last[k] = src_last[k][src_head[k]];
      end else begin
        req_valid[k] = 1'b0;
        req_data[k*DW +: DW] = '0;
        req_last[k] = 1'b0;
      end
    end
    tx_pready = (pready_mode == 0) ? 1'b0 : (pready_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
    #1;
    if (grant != '0 && prev_grant == '0) begin
      for (int j = 0; j < NR; j++) if (grant[j]) glog.push_back(j);
    end
    prev_grant = grant;
    if (tx_pdata_valid && tx_pready) obs_q.push_back(tx_pdata);
    for (int k = 0; k < NR; k++) begin
      if (req_valid[k] && req_ready[k]) begin
        src_head[k] = src_head[k] + 1;
        acc_edge[k] = cyc + 1;
      end
    end
  endtask

  task automatic test_reset();
    prst_n = 1'b0;
    #1;
    n_cmp++;
    if ({tx_pdata, tx_pdata_valid, req_ready, grant, grant_id, busy} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_values: got %h required 0", {tx_pdata, tx_pdata_valid, req_ready, grant, grant_id, busy});
    end
    do_reset();
    push_src(0, 8'h55, 1'b1);
    step();
    n_cmp++;
    if (grant !== 4'b0000) begin n_fail++; $display("FAIL single_idle_grant: got %b required 0000", grant); end
    step();
    n_cmp++;
    if (grant !== 4'b0001 || req_ready !== 4'b0001 || tx_pdata_valid !== 1'b0 || grant_id !== 2'd0) begin
      n_fail++;
      $display("FAIL single_grant: got grant=%b ready=%b valid=%b id=%0d required 0001/0001/0/0", grant, req_ready, tx_pdata_valid, grant_id);
    end
    step();
    n_cmp++;
    if (tx_pdata !== 8'h55 || tx_pdata_valid !== 1'b1 || grant !== 4'b0000 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_data: got data=%h valid=%b grant=%b busy=%b required 55/1/0000/1", tx_pdata, tx_pdata_valid, grant, busy);
    end
    step();
    n_cmp++;
    if (tx_pdata_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_drain: got valid=%b busy=%b required 0/0", tx_pdata_valid, busy);
    end
  endtask

  task automatic test_round_robin();
    int exp_g[5] = '{0, 1, 2, 3, 0};
    int guard;
    do_reset();
    for (int k = 0; k < NR; k++)
      for (int n = 0; n < 3; n++) push_src(k, 8'(k*16 + n), 1'b1);
    guard = 0;
    while (glog.size() < 5 && guard < 40) begin step(); guard++; end
    repeat (3) step();
    n_cmp++;
    if (glog.size() < 5 || obs_q.size() < 5) begin
      n_fail++;
      $display("FAIL rr_timeout: got %0d grants %0d bytes required 5/5", glog.size(), obs_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if (glog[i] != exp_g[i] || obs_q[i] !== 8'(exp_g[i]*16 + i/4)) begin
          n_fail++;
          $display("FAIL rr_order[%0d]: got req %0d byte %h required req %0d byte %h", i, glog[i], obs_q[i], exp_g[i], 8'(exp_g[i]*16 + i/4));
        end
      end
    end
  endtask

  task automatic test_burst_cap();
    logic [7:0] exp_b[11] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'hB0, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    int exp_g[4] = '{2, 1, 2, 2};
    int guard;
    do_reset();
    for (int n = 0; n < 10; n++) push_src(2, 8'(n), 1'b0);
    push_src(1, 8'hB0, 1'b1);
    src_en[1] = 1'b0;
    step();
    src_en[1] = 1'b1;
    guard = 0;
    while (obs_q.size() < 11 && guard < 150) begin step(); guard++; end
    n_cmp++;
    if (obs_q.size() < 11 || glog.size() < 4) begin
      n_fail++;
      $display("FAIL cap_timeout: got %0d bytes %0d grants required 11/4", obs_q.size(), glog.size());
    end else begin
      for (int i = 0; i < 11; i++) begin
        n_cmp++;
        if (obs_q[i] !== exp_b[i]) begin
          n_fail++;
          $display("FAIL cap_byte[%0d]: got %h required %h", i, obs_q[i], exp_b[i]);
        end
      end
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (glog[i] != exp_g[i]) begin
          n_fail++;
          $display("FAIL cap_grant[%0d]: got %0d required %0d", i, glog[i], exp_g[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int guard;
    do_reset();
    push_src(0, 8'hA3, 1'b0);
    for (int n = 1; n < 32; n++) push_src(0, 8'($urandom), 1'b0);
    pready_mode = 0;
    guard = 0;
    while (tx_pdata_valid !== 1'b1 && guard < 10) begin step(); guard++; end
    for (int c = 0; c < 5; c++) begin
      if (c > 0) step();
      n_cmp++;
      if (tx_pdata !== 8'hA3 || tx_pdata_valid !== 1'b1 || req_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got data=%h valid=%b ready=%b required a3/1/0000", c, tx_pdata, tx_pdata_valid, req_ready);
      end
    end
    pready_mode = 2;
    guard = 0;
    while (obs_q.size() < 32 && guard < 600) begin step(); guard++; end
    pready_mode = 1;
    repeat (20) step();
    n_cmp++;
    if (obs_q.size() != 32) begin
      n_fail++;
      $display("FAIL bp_count: got %0d bytes required 32", obs_q.size());
    end else begin
      for (int i = 0; i < 32; i++) begin
        n_cmp++;
        if (obs_q[i] !== src_data[0][i]) begin
          n_fail++;
          $display("FAIL bp_byte[%0d]: got %h required %h", i, obs_q[i], src_data[0][i]);
        end
      end
    end
  endtask

  task automatic test_idle_timeout();
    int guard, rel;
    do_reset();
    push_src(1, 8'h11, 1'b0);
    push_src(1, 8'h12, 1'b0);
    push_src(3, 8'h33, 1'b1);
    src_en[3] = 1'b0;
    step();
    src_en[3] = 1'b1;
    guard = 0;
    while (src_head[1] < 2 && guard < 20) begin step(); guard++; end
    guard = 0;
    while (grant !== 4'b0000 && guard < 30) begin step(); guard++; end
    rel = cyc;
    n_cmp++;
    if (rel - acc_edge[1] != IT) begin
      n_fail++;
      $display("FAIL idle_release: got %0d cycles after last accept required %0d", rel - acc_edge[1], IT);
    end
    guard = 0;
    while (grant === 4'b0000 && guard < 5) begin step(); guard++; end
    n_cmp++;
    if (grant !== 4'b1000 || grant_id !== 2'd3) begin
      n_fail++;
      $display("FAIL idle_next_grant: got grant=%b id=%0d required 1000/3", grant, grant_id);
    end
  endtask

  task automatic test_reset_mid_burst();
    int guard;
    do_reset();
    for (int n = 0; n < 5; n++) push_src(0, 8'(8'hC0 + n), 1'b0);
    guard = 0;
    while (src_head[0] < 2 && guard < 20) begin step(); guard++; end
    step();
    #1 prst_n = 1'b0;
    #1;
    n_cmp++;
    if ({tx_pdata, tx_pdata_valid, req_ready, grant, grant_id, busy} !== 20'h0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %h required 0", {tx_pdata, tx_pdata_valid, req_ready, grant, grant_id, busy});
    end
    do_reset();
    push_src(0, 8'h01, 1'b1);
    push_src(1, 8'h02, 1'b1);
    step();
    step();
    n_cmp++;
    if (grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL midreset_first: got %b required 0001", grant);
    end
  endtask

  task automatic test_random();
    logic [7:0] expq[$];
    int pos[NR];
    int guard, bad, k, n;
    logic done;
    do_reset();
    for (int r = 0; r < NR; r++)
      for (int i = 0; i < 40; i++) push_src(r, 8'($urandom), ($urandom_range(0, 3) == 0));
    pready_mode = 2;
    guard = 0;
    bad = 0;
    while (obs_q.size() < 60 && guard < 3000) begin
      step();
      guard++;
      if ($countones(req_ready) > 1 || (req_ready & ~grant) != '0) bad++;
    end
    // Round robin over always-valid requesters; a burst ends on last or MB bytes.
    for (int r = 0; r < NR; r++) pos[r] = 0;
    k = 0;
    while (expq.size() < 60) begin
      n = 0;
      done = 1'b0;
      while (!done) begin
        expq.push_back(src_data[k][pos[k]]);
        done = src_last[k][pos[k]] || (n + 1 == MB);
        pos[k]++;
        n++;
      end
      k = (k + 1) % NR;
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL rand_ready_onehot: got %0d bad cycles required 0", bad);
    end
    n_cmp++;
    if (obs_q.size() < 60) begin
      n_fail++;
      $display("FAIL rand_timeout: got %0d bytes required 60", obs_q.size());
    end else begin
      for (int i = 0; i < 60; i++) begin
        n_cmp++;
        if (obs_q[i] !== expq[i]) begin
          n_fail++;
          $display("FAIL rand_byte[%0d]: got %h required %h", i, obs_q[i], expq[i]);
        end
      end
    end
  endtask

  initial begin
    prst_n = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0; tx_pready = 1'b1;
    prev_grant = '0;
    test_reset();
    test_round_robin();
    test_burst_cap();
    test_backpressure();
    test_idle_timeout();
    test_reset_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single `uart_tx` parallel input among `NUM_REQ` byte-stream requesters in the `pclk_i` domain. A grant is held for one burst. The burst ends on the requester's `req_last_i`, after `MAX_BURST` bytes, or after `IDLE_TIMEOUT` cycles with no valid data. The block sits between the requesters and `uart_tx.tx_pdata_i / tx_pdata_valid_i / tx_pready_o`, with one registered output stage.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters (2..8).
- `DATA_WIDTH`, default 8: byte width; matches `uart_tx`.
- `MAX_BURST`, default 16: maximum bytes per grant (1..255).
- `IDLE_TIMEOUT`, default 8: cycles without `req_valid_i` from the granted requester before the grant is released (1..255).
- `ID_WIDTH`, default 2: width of `grant_id_o`; equals clog2(`NUM_REQ`).

Ports:
- `pclk_i`, in, 1: parallel clock. Single clock, rising edge.
- `prst_n_i`, in, 1: reset, asynchronous, active-low.
- `req_data_i`, in, `NUM_REQ*DATA_WIDTH`: requester k uses bits [k*DATA_WIDTH +: DATA_WIDTH].
- `req_valid_i`, in, `NUM_REQ`: per-requester byte valid.
- `req_last_i`, in, `NUM_REQ`: marks the final byte of a burst; qualified by valid.
- `req_ready_o`, out, `NUM_REQ`: per-requester ready. Only the granted bit may be high.
- `tx_pdata_o`, out, `DATA_WIDTH`: byte to `uart_tx`.
- `tx_pdata_valid_o`, out, 1: byte valid to `uart_tx`.
- `tx_pready_i`, in, 1: ready from `uart_tx`.
- `grant_o`, out, `NUM_REQ`: one-hot current grant. All zero when no requester is granted.
- `grant_id_o`, out, `ID_WIDTH`: index of the current or most recent grant.
- `busy_o`, out, 1: high in state XFER, or while the output register holds a byte.

## Operation
- **States.** Two states: IDLE and XFER.
- **IDLE.**
  - When any `req_valid_i` is high, pick the first valid requester strictly after `last_ptr`, in increasing index order with wrap.
  - Register `grant_o`, `grant_id_o`, `last_ptr` := winner, and clear `burst_cnt` and `idle_cnt`.
  - Go to XFER.
  - When no request is valid, stay in IDLE.
- **Output register.** Holds `tx_pdata_o` and `tx_pdata_valid_o`.
  - Load condition `load` = XFER && `req_valid_i[g]` && (!`tx_pdata_valid_o` || `tx_pready_i`).
  - `req_ready_o[g]` = XFER && (!`tx_pdata_valid_o` || `tx_pready_i`), combinational. All other bits are 0.
  - When `tx_pdata_valid_o` && `tx_pready_i` and there is no `load`, `tx_pdata_valid_o` clears.
- **XFER.**
  - Each `load` increments `burst_cnt` and clears `idle_cnt`.
  - Each cycle with !`req_valid_i[g]` increments `idle_cnt`.
- **Release.** Clear `grant_o`, then return to IDLE on the next edge, when any of these holds:
  - `load` && `req_last_i[g]`;
  - `load` && `burst_cnt` == `MAX_BURST`-1;
  - `idle_cnt` == `IDLE_TIMEOUT`-1 with no valid.
  - Simultaneous release conditions cause a single release.
- **After release.** A byte still held in the output register drains normally. Arbitration proceeds even while that byte is pending.
- **Fairness.** The pointer advances only on grant. A requester that withdraws valid before its grant registers loses nothing; it is picked again on its next request.
- **Reset mid-burst.** All state is cleared and any held byte is discarded. There is no partial-burst recovery.

## Timing
- **Reset values.**
  - Outputs: `tx_pdata_o`=0, `tx_pdata_valid_o`=0, `req_ready_o`=0, `grant_o`=0, `grant_id_o`=0, `busy_o`=0.
  - Internal: state IDLE, `last_ptr`=`NUM_REQ`-1, so requester 0 wins first.
- **Grant latency.** Request seen in IDLE at cycle n gives `grant_o` and `req_ready_o[g]` at n+1.
- **Data latency.**
  - The first byte is accepted at the end of n+1 and `tx_pdata_valid_o` rises at n+2.
  - Data latency is 1 cycle from accept to `tx_pdata_valid_o`.
- **Throughput.** With `tx_pready_i` held high, one byte per cycle is sustained within a burst.
- **Burst gap.** Minimum gap between bursts is one IDLE cycle.
- **Output stability.** `tx_pdata_o` is stable while `tx_pdata_valid_o` && !`tx_pready_i`.

## Structure
- **Package `uart_arb_pkg`:**
  - state enum (IDLE, XFER);
  - default localparams for `NUM_REQ`, `MAX_BURST` and `IDLE_TIMEOUT`;
  - a clog2 helper function.
- **Sub-module `rr_pick`:** combinational. Inputs are a request mask and a pointer; outputs are a one-hot winner and its index. It is reusable by the RX-side FIFO drain scheduler.

## Test plan
- **Reset and single byte.** After reset, req0 valid with byte 0x55 and last=1 at cycle 0 → `grant_o`=0001 at cycle 1 and `tx_pdata_o`=0x55 valid at cycle 2 → back to IDLE at cycle 2.
- **Round robin.** All four requesters always valid, each byte last=1 → grant order 0,1,2,3,0, one byte each.
- **Burst cap.** `MAX_BURST`=4; req2 sends 10 bytes 0x00..0x09 with no last, and req1 is also requesting → req2 sends 0x00..0x03, then req1 is granted, then req2 resumes at 0x04.
- **Backpressure.** `tx_pready_i` low for 5 cycles with byte 0xA3 held → `tx_pdata_o` stays 0xA3 and `req_ready_o` stays 0 throughout. No byte is lost or duplicated over a 32-byte scoreboard check.
- **Idle timeout.** `IDLE_TIMEOUT`=8; req1 sends 2 bytes then drops valid → grant released exactly 8 cycles after the last accept, and req3, which is pending, is granted next.
- **Reset mid-burst.** `prst_n_i` asserted during req0's third byte → all outputs 0 immediately (asynchronous). After release, requester 0 wins first again.
